// File: rtl/fine_cfo_pkg.sv
// Shared constants, types and arctangent table for the fine CFO estimator.
package fine_cfo_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned PHASE_W     = 16;
    localparam int unsigned CORDIC_ITER = 16;
    localparam int unsigned LAG         = 64;
    localparam int unsigned ACC_W       = 40;
    localparam int unsigned ACC_SHIFT   = 14;
    localparam int unsigned CORDIC_W    = 28;
    localparam int unsigned Z_W         = 18;
    localparam int unsigned CNT_W       = $clog2(LAG);
    localparam int unsigned IT_W        = $clog2(CORDIC_ITER);

    // round(atan(2^-i) * 2^15 / pi): micro-rotation angles in units of pi/2^15
    localparam logic signed [15:0] ATAN [CORDIC_ITER] = '{
        16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297,
        16'sd651,  16'sd326,  16'sd163,  16'sd81,
        16'sd41,   16'sd20,   16'sd10,   16'sd5,
        16'sd3,    16'sd1,    16'sd1,    16'sd0
    };

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CORR,
        CORDIC,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] i;
        logic signed [DATA_W-1:0] q;
    } cplx_t;

endpackage

// File: rtl/fine_cfo_estimate_if.sv
// Valid/ready sample stream feeding the fine CFO estimator.
interface fine_cfo_estimate_if;
    import fine_cfo_pkg::*;

    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_i;
    logic signed [DATA_W-1:0] s_q;

    modport master (output s_valid, output s_i, output s_q, input s_ready);
    modport slave  (input s_valid, input s_i, input s_q, output s_ready);

endinterface

// File: rtl/fine_cfo_cordic_atan.sv
// Iterative vectoring CORDIC: one micro-rotation per cycle, angle out in pi/2^15 units.
module fine_cfo_cordic_atan
    import fine_cfo_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic signed [CORDIC_W-1:0] x_in,
    input  logic signed [CORDIC_W-1:0] y_in,
    output logic                       done,
    output logic signed [PHASE_W-1:0]  phase
);

    localparam logic signed [Z_W-1:0] Z_PI = Z_W'(2**(PHASE_W-1));

    logic signed [CORDIC_W-1:0] x, y;
    logic signed [CORDIC_W-1:0] xs_c, ys_c;
    logic signed [Z_W-1:0]      z;
    logic signed [Z_W-1:0]      atan_c;
    logic [IT_W-1:0]            it;
    logic                       run;
    logic                       zero;

    assign xs_c   = x >>> it;
    assign ys_c   = y >>> it;
    assign atan_c = Z_W'(ATAN[it]);
    assign phase  = z[PHASE_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            z    <= '0;
            it   <= '0;
            run  <= 1'b0;
            zero <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                zero <= (x_in == '0) && (y_in == '0);
                it   <= '0;
                run  <= 1'b1;
                // Left half-plane: rotate by pi so the iterations only cover +-pi/2
                if (x_in[CORDIC_W-1]) begin
                    x <= -x_in;
                    y <= -y_in;
                    z <= y_in[CORDIC_W-1] ? -Z_PI : Z_PI;
                end else begin
                    x <= x_in;
                    y <= y_in;
                    z <= '0;
                end
            end else if (run) begin
                if (y[CORDIC_W-1]) begin
                    x <= x - ys_c;
                    y <= y + xs_c;
                    z <= z - atan_c;
                end else begin
                    x <= x + ys_c;
                    y <= y - xs_c;
                    // A zero vector has no angle; keep z at 0 instead of summing the table
                    if (!zero) begin
                        z <= z + atan_c;
                    end
                end
                it <= it + IT_W'(1);
                if (it == IT_W'(CORDIC_ITER-1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fine_cfo_estimate.sv
// Fine CFO estimator: lag-LAG autocorrelation over the two LTS symbols, then CORDIC angle.
module fine_cfo_estimate
    import fine_cfo_pkg::*;
(
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      start,
    fine_cfo_estimate_if.slave        s,
    output logic                      busy,
    output logic                      est_valid,
    output logic signed [PHASE_W-1:0] phase_inc,
    output logic signed [ACC_W-1:0]   corr_re,
    output logic signed [ACC_W-1:0]   corr_im
);

    state_t                      state, state_n;
    logic [CNT_W-1:0]            cnt;
    logic signed [ACC_W-1:0]     acc_re, acc_im;
    cplx_t                       lts1_mem [LAG];
    cplx_t                       a_c, b_c;
    logic signed [DATA_W-1:0]    a_i, a_q, b_i, b_q;
    logic signed [2*DATA_W-1:0]  p_ii, p_qq, p_iq, p_qi;
    logic                        accept_c, last_c;
    logic                        cordic_load, cordic_done;
    logic signed [PHASE_W-1:0]   cordic_phase;

    assign accept_c = s.s_valid && s.s_ready;
    assign last_c   = (cnt == CNT_W'(LAG-1));

    // conj(a) * b with a from LTS1 and b the live LTS2 sample
    assign b_c  = {s.s_i, s.s_q};
    assign a_c  = lts1_mem[cnt];
    assign a_i  = a_c.i;
    assign a_q  = a_c.q;
    assign b_i  = b_c.i;
    assign b_q  = b_c.q;
    assign p_ii = a_i * b_i;
    assign p_qq = a_q * b_q;
    assign p_iq = a_i * b_q;
    assign p_qi = a_q * b_i;

    always_ff @(posedge ap_clk) begin
        if (state == FILL && accept_c) begin
            lts1_mem[cnt] <= b_c;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = FILL;
            FILL:    if (accept_c && last_c) state_n = CORR;
            CORR:    if (accept_c && last_c) state_n = CORDIC;
            CORDIC:  if (cordic_done) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_re      <= '0;
            acc_im      <= '0;
            s.s_ready   <= 1'b0;
            busy        <= 1'b0;
            est_valid   <= 1'b0;
            cordic_load <= 1'b0;
            phase_inc   <= '0;
            corr_re     <= '0;
            corr_im     <= '0;
        end else begin
            state       <= state_n;
            s.s_ready   <= (state_n == FILL) || (state_n == CORR);
            busy        <= (state_n != IDLE);
            est_valid   <= 1'b0;
            cordic_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) cnt <= '0;
                end
                FILL: begin
                    if (accept_c) begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_c) begin
                            acc_re <= '0;
                            acc_im <= '0;
                        end
                    end
                end
                CORR: begin
                    if (accept_c) begin
                        cnt         <= cnt + CNT_W'(1);
                        acc_re      <= acc_re + ACC_W'(p_ii) + ACC_W'(p_qq);
                        acc_im      <= acc_im + ACC_W'(p_iq) - ACC_W'(p_qi);
                        cordic_load <= last_c;
                    end
                end
                CORDIC: begin
                    // Angle over LAG samples in pi/2^15 equals per-sample increment in pi/2^21
                    if (cordic_done) begin
                        phase_inc <= cordic_phase;
                        corr_re   <= acc_re;
                        corr_im   <= acc_im;
                        est_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    fine_cfo_cordic_atan u_cordic (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .load  (cordic_load),
        .x_in  (CORDIC_W'(acc_re >>> ACC_SHIFT)),
        .y_in  (CORDIC_W'(acc_im >>> ACC_SHIFT)),
        .done  (cordic_done),
        .phase (cordic_phase)
    );

endmodule

// File: tb/tb_fine_cfo_estimate.sv
// Scoreboard bench for fine_cfo_estimate: tone/zero/random stimulus against a complex-math model.
module tb_fine_cfo_estimate;
    import fine_cfo_pkg::*;

    localparam int  L  = 64;
    localparam int  NS = 2 * L;
    localparam real PI = 3.14159265358979323846;

    logic                ap_clk = 1'b0;
    logic                ap_rst_n;
    logic                start;
    logic                busy;
    logic                est_valid;
    logic signed [15:0]  phase_inc;
    logic signed [39:0]  corr_re;
    logic signed [39:0]  corr_im;

    fine_cfo_estimate_if sif ();

    fine_cfo_estimate dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .start     (start),
        .s         (sif),
        .busy      (busy),
        .est_valid (est_valid),
        .phase_inc (phase_inc),
        .corr_re   (corr_re),
        .corr_im   (corr_im)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int     phase;
        int     tol;
        longint re;
        longint im;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    int   n_est    = 0;
    int   smp_i [NS];
    int   smp_q [NS];

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Circular distance between two phases on the 16-bit wrap
    function automatic int pdiff(input int a, input int b);
        int d;
        d = (a - b) % 65536;
        if (d > 32767)  d -= 65536;
        if (d < -32768) d += 65536;
        return d;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic gen_tone(input real amp, input real w, input int noise);
        real ph0;
        ph0 = real'($urandom_range(0, 6283)) / 1000.0;
        for (int n = 0; n < NS; n++) begin
            smp_i[n] = int'(amp * $cos(w * real'(n) + ph0));
            smp_q[n] = int'(amp * $sin(w * real'(n) + ph0));
            if (noise > 0) begin
                smp_i[n] += int'($urandom_range(2 * noise)) - noise;
                smp_q[n] += int'($urandom_range(2 * noise)) - noise;
            end
        end
    endtask

    task automatic gen_zero();
        for (int n = 0; n < NS; n++) begin
            smp_i[n] = 0;
            smp_q[n] = 0;
        end
    endtask

    // Reference: sum over the first symbol of conj(x[n]) * x[n+L]
    task automatic ref_corr(output longint re, output longint im);
        re = 0;
        im = 0;
        for (int n = 0; n < L; n++) begin
            re += longint'(smp_i[n]) * smp_i[n+L] + longint'(smp_q[n]) * smp_q[n+L];
            im += longint'(smp_i[n]) * smp_q[n+L] - longint'(smp_q[n]) * smp_i[n+L];
        end
    endtask

    function automatic int ideal_phase(input longint re, input longint im);
        longint x;
        longint y;
        x = re >>> 14;
        y = im >>> 14;
        if (x == 0 && y == 0) return 0;
        return int'($atan2(real'(y), real'(x)) * 32768.0 / PI);
    endfunction

    always @(negedge ap_clk) begin
        if (est_valid) begin
            n_est++;
            chk("est_expected", sb.size() > 0, sb.size(), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("latency", (cyc - last_acc) == 18, cyc - last_acc, 18);
                chk("phase_inc", iabs(pdiff(int'(phase_inc), mon_e.phase)) <= mon_e.tol,
                    int'(phase_inc), mon_e.phase);
                chk("corr_re", longint'(corr_re) == mon_e.re, longint'(corr_re), mon_e.re);
                chk("corr_im", longint'(corr_im) == mon_e.im, longint'(corr_im), mon_e.im);
            end
        end
    end

    task automatic do_start();
        @(posedge ap_clk); #1;
        start = 1'b1;
        @(posedge ap_clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int nsamp, input int gap_pct, input int start_at);
        int n;
        int guard;
        bit pulsed;
        n = 0;
        guard = 0;
        pulsed = 1'b0;
        while (n < nsamp && guard < 4000) begin
            @(posedge ap_clk); #1;
            guard++;
            start = (n == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            sif.s_valid = (int'($urandom_range(99)) >= gap_pct);
            sif.s_i = sif.s_valid ? 16'(smp_i[n]) : 16'($urandom);
            sif.s_q = sif.s_valid ? 16'(smp_q[n]) : 16'($urandom);
            @(negedge ap_clk);
            if (sif.s_valid && sif.s_ready) begin
                n++;
                last_acc = cyc + 1;
            end
        end
        @(posedge ap_clk); #1;
        sif.s_valid = 1'b0;
        start = 1'b0;
        chk("samples_accepted", n == nsamp, n, nsamp);
    endtask

    task automatic wait_est(input int n_before, input int n_exp);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge ap_clk);
            t++;
        end
        repeat (5) @(posedge ap_clk);
        #1;
        chk("est_count", (n_est - n_before) == n_exp, n_est - n_before, n_exp);
        chk("busy_after", busy == 1'b0, busy, 0);
        sb.delete();
    endtask

    task automatic run_case(input int exp_phase, input bit use_ideal, input int tol,
                            input int gap_pct, input int start_at);
        longint re;
        longint im;
        int n0;
        ref_corr(re, im);
        sb.push_back('{phase: use_ideal ? ideal_phase(re, im) : exp_phase,
                       tol: tol, re: re, im: im});
        n0 = n_est;
        do_start();
        send(NS, gap_pct, start_at);
        wait_est(n0, 1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"},      busy == 1'b0,        busy,                0);
        chk({tag, "_est_valid"}, est_valid == 1'b0,   est_valid,           0);
        chk({tag, "_s_ready"},   sif.s_ready == 1'b0, sif.s_ready,         0);
        chk({tag, "_phase_inc"}, phase_inc == '0,     int'(phase_inc),     0);
        chk({tag, "_corr_re"},   corr_re == '0,       longint'(corr_re),   0);
        chk({tag, "_corr_im"},   corr_im == '0,       longint'(corr_im),   0);
    endtask

    initial begin
        int n0;
        int k;
        real amp;

        ap_rst_n    = 1'b0;
        start       = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_i     = '0;
        sif.s_q     = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        check_cleared("reset");
        ap_rst_n = 1'b1;

        // Directed tones: correlation angles pi/4, -pi/2, 3pi/4, -3pi/4
        gen_tone(8000.0, PI / 256.0, 0);
        run_case(8192, 1'b0, 2, 0, -1);
        gen_tone(8000.0, -PI / 128.0, 0);
        run_case(-16384, 1'b0, 2, 0, -1);
        gen_tone(8000.0, 3.0 * PI / 256.0, 0);
        run_case(24576, 1'b0, 2, 0, -1);
        gen_tone(8000.0, -3.0 * PI / 256.0, 0);
        run_case(-24576, 1'b0, 2, 0, -1);

        gen_zero();
        run_case(0, 1'b0, 0, 0, -1);

        // Stalls on s_valid plus a start pulse while correlating
        gen_tone(8000.0, PI / 256.0, 0);
        run_case(8192, 1'b0, 2, 50, 90);

        // Abort after 100 samples with a one-cycle reset
        gen_tone(8000.0, PI / 256.0, 0);
        n0 = n_est;
        do_start();
        send(100, 0, -1);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        check_cleared("midrst");
        ap_rst_n = 1'b1;
        repeat (40) @(posedge ap_clk);
        #1;
        chk("midrst_no_est", n_est == n0, n_est - n0, 0);

        gen_tone(8000.0, PI / 256.0, 0);
        run_case(8192, 1'b0, 2, 0, -1);

        // Random tones checked against the ideal angle of the reference correlation
        for (int r = 0; r < 6; r++) begin
            amp = real'($urandom_range(2000, 30000));
            k   = int'($urandom_range(1000)) - 500;
            gen_tone(amp, real'(k) * PI / 32768.0, 40);
            run_case(0, 1'b1, 5, int'($urandom_range(60)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fine_cfo_estimate.md
Name: fine_cfo_estimate

Overview:
Fine CFO estimator that produces the per-sample phase increment consumed by the fine CFO apply stage of the synchronization chain. It sits downstream of timing sync and upstream of CFO apply. It captures the two 64-sample long training symbols (LTS1, LTS2) and accumulates the lag-64 autocorrelation sum of conj(x[n])*x[n+64]. A sequential CORDIC then converts the sum's angle to a fixed-point phase increment per sample.

Parameters:
DATA_W, 16, signed I/Q sample width
LAG, 64, LTS length and correlation lag (power of two)
ACC_W, 40, signed accumulator width per component
ACC_SHIFT, 14, arithmetic right shift applied to the accumulator before the CORDIC
CORDIC_W, 28, CORDIC X/Y datapath width, including growth guard
CORDIC_ITER, 16, number of CORDIC micro-rotations
PHASE_W, 16, output phase width

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; the next accepted sample is LTS1[0]
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_i  in  DATA_W  sample I, signed
s_q  in  DATA_W  sample Q, signed
busy  out  1  high in any state except IDLE
est_valid  out  1  one-cycle pulse when phase_inc is updated
phase_inc  out  PHASE_W  signed phase increment; LSB = pi/2^21 rad/sample
corr_re  out  ACC_W  final accumulator, real part; held with phase_inc
corr_im  out  ACC_W  final accumulator, imaginary part; held with phase_inc

Behaviour:
- Reset, and any cycle with ap_rst_n=0: state=IDLE. All outputs are 0. Sample counter and accumulators are 0. Buffer contents are don't-care.
- A sample is accepted when s_valid && s_ready. s_ready=1 only in FILL and CORR. Gaps in s_valid stall the block with no state change.
- IDLE: s_ready=0. On start, go to FILL and set cnt=0. A sample presented in the same cycle as start is not accepted.
- FILL: each accepted sample is written to buf[cnt] and cnt is incremented. After the LAG-th acceptance, cnt wraps to 0, accumulators clear, and the state goes to CORR.
- CORR: each accepted sample b is paired with a=buf[cnt]:
  - acc_re += aI*bI + aQ*bQ
  - acc_im += aI*bQ - aQ*bI
  - Products are full-precision 2*DATA_W bits; sums are sign-extended to ACC_W. No saturation (ACC_W has headroom for LAG=64).
  - After the LAG-th acceptance, go to CORDIC.
- CORDIC:
  - Load cycle: X=acc_re>>>ACC_SHIFT and Y=acc_im>>>ACC_SHIFT, sign-extended to CORDIC_W.
  - Pre-rotation in the same cycle: if X<0, set X=-X and Y=-Y, and z0=+2^15 if the original Y>=0, else -2^15. Otherwise z0=0. z is 18 bits.
  - Then CORDIC_ITER vectoring iterations, one per cycle: d = (Y<0)?+1:-1; X -= d*(Y>>>i); Y += d*(X>>>i); z -= d*ATAN[i].
  - ATAN[i] = round(atan(2^-i)*2^15/pi).
- DONE: z is wrapped modulo 2^16 into phase_inc. The angle over LAG samples in pi/2^15 units equals the per-sample increment in pi/2^21 units, so no shift is applied. corr_re/corr_im are latched, est_valid pulses, and the state returns to IDLE.
- Latency: est_valid is asserted exactly 18 cycles after the cycle that accepted the 128th sample (1 load + 16 iterations + 1 DONE).
- start while busy: ignored.
- Zero correlation (X=Y=0): phase_inc=0.
- Angle exactly ±pi: phase_inc=-32768.
- phase_inc, corr_re and corr_im hold between estimates.
- Reset mid-operation aborts the estimate. No est_valid is issued, and the next start begins a fresh FILL.

Decomposition:
- Package fine_cfo_pkg:
  - the DATA_W, PHASE_W and CORDIC_ITER constants;
  - the ATAN lookup constant array (16 x 16-bit);
  - the state enum {IDLE, FILL, CORR, CORDIC, DONE};
  - a complex-sample struct type.
- Sub-module fine_cfo_cordic_atan: iterative vectoring CORDIC with load/done handshake, instantiated once.
- The LTS1 buffer is inferred as a 64-deep simple dual-port RAM.

Test Plan:
- Amplitude 8000 tone, rotation +pi/256 per sample, 128 samples back-to-back -> est_valid at 18 cycles; phase_inc = 8192 +/-2; corr_im > 0.
- Rotation -pi/128 per sample -> phase_inc = -16384 +/-2.
- Rotation +3pi/256 per sample (correlation angle 3pi/4, exercises X<0 pre-rotation) -> 24576 +/-2. Rotation -3pi/256 -> -24576 +/-2.
- All-zero samples -> phase_inc=0, corr_re=corr_im=0, est_valid once.
- Random s_valid gaps (about 50% duty), plus a start pulse injected mid-CORR -> same phase_inc as the back-to-back run; the second start is ignored; exactly one est_valid.
- ap_rst_n low for 1 cycle after 100 samples -> all outputs 0 and no est_valid. A fresh start with the +pi/256 stimulus -> phase_inc = 8192 +/-2.
